internal_bus_arbiter: RTL and testbench
=======================================

Name: internal_bus_arbiter

Overview:
Arbitrates ownership of the 8-bit internal bus between multiple requesters: datapath register drivers, ALU result and address-low/high latches. Grants are round-robin with a bounded hold time. The block drives a one-hot bus select and the muxed bus data, so at most one source ever drives the bus. It sits between the control-signal decoder and the internal bus datapath.

Parameters:
REQUESTERS, 4, number of bus sources; legal range 2..16.
WIDTH, 8, bus data width in bits.
MAX_HOLD, 8, maximum consecutive cycles one owner keeps the bus while others wait; must be >= 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
nrst  input  1  asynchronous active-low reset.
busRequest  input  REQUESTERS  per-source request, level-sensitive.
busInputs  input  WIDTH*REQUESTERS  packed source data; source i occupies bits [WIDTH*(i+1)-1 : WIDTH*i].
busSelect  output  REQUESTERS  one-hot grant, registered; all zero when idle.
grantValid  output  1  high when any grant is active, registered.
grantId  output  $clog2(REQUESTERS)  binary index of the owner, registered; 0 when idle.
busOutput  output  WIDTH  combinational: busInputs slice of the owner when grantValid, else all zeros.

Behaviour:
- Reset (nrst low, asynchronous) sets: busSelect=0, grantValid=0, grantId=0, state=IDLE, holdCount=0, rrPointer=REQUESTERS-1, so source 0 has first priority after reset.
- States: IDLE and OWNED.
- IDLE: if any busRequest bit is high, pick the first requester scanning rrPointer+1, rrPointer+2, ... (mod REQUESTERS).
  - On the next edge: load busSelect, grantId and rrPointer with the winner, set grantValid=1, set holdCount=0, go to OWNED.
  - Request-to-grant latency is 1 cycle.
- OWNED, evaluated each edge (owner = grantId):
  - Owner drops its request, others pending: grant passes directly to the next round-robin winner at that edge (no idle bubble); holdCount=0.
  - Owner drops its request, none pending: busSelect=0, grantValid=0, grantId=0, go to IDLE; rrPointer keeps the last owner.
  - Owner still requesting, holdCount == MAX_HOLD-1, another request pending: forced rotation to the next round-robin winner, excluding the owner; holdCount=0.
  - Owner still requesting, holdCount == MAX_HOLD-1, nothing else pending: owner keeps the bus; holdCount=0.
  - Otherwise: holdCount increments.
- holdCount width is $clog2(MAX_HOLD) and it never exceeds MAX_HOLD-1.
- busSelect is always one-hot or zero, and always consistent with grantId and grantValid.
- A request that appears and disappears between edges is never seen and never granted.
- busOutput follows busInputs combinationally while granted; there is no data latency beyond the grant.
- Mid-operation reset: all outputs return to reset values immediately. The next grant after reset follows source-0-first priority.

Optional Feature:
INTERNAL_BUS_ARB_LOCK_EN:
- Defined: adds input busLock (1 bit). While busLock is high and grantValid is high, forced rotation is suppressed; holdCount saturates at MAX_HOLD-1. Voluntary release (owner dropping its request) still applies. busLock has no effect in IDLE.
- Undefined: the busLock port is absent and forced rotation always applies.

Test Plan:
- Reset hold, then release with REQUESTERS=4 and busRequest=0 -> busSelect=0000, grantValid=0, grantId=0, busOutput=0x00.
- busRequest=0100 at cycle 0, busInputs slice 2 = 0xA5 -> at cycle 1 busSelect=0100, grantId=2, busOutput=0xA5.
- busRequest=1111, each owner drops its request 1 cycle after being granted -> grant order 0,1,2,3,0 with no idle cycles between owners.
- MAX_HOLD=8, source 1 held high, source 3 requests at cycle 2 -> source 1 owns exactly 8 cycles, then busSelect=1000. With source 3 absent, source 1 keeps the bus indefinitely.
- Owner 2 is granted, nrst pulsed low mid-grant while busRequest=1111 -> outputs clear asynchronously; the first grant after reset goes to source 0.
- With INTERNAL_BUS_ARB_LOCK_EN: busLock=1, sources 0 and 1 requesting -> source 0 holds for 20 cycles with no rotation. Dropping busLock -> source 1 is granted on the next edge.

Source files
------------

// File: rtl/internal_bus_arbiter_if.sv
// Internal bus arbitration interface: per-source requests/data in, one-hot grant and muxed data out.
// The arbiter connects through the slave modport; the requesting datapath uses master.
interface internal_bus_arbiter_if #(
  parameter int REQUESTERS = 4,
  parameter int WIDTH      = 8
);
  localparam int IDW = $clog2(REQUESTERS);

  logic [REQUESTERS-1:0]       busRequest;
  logic [WIDTH*REQUESTERS-1:0] busInputs;
  logic [REQUESTERS-1:0]       busSelect;
  logic                        grantValid;
  logic [IDW-1:0]              grantId;
  logic [WIDTH-1:0]            busOutput;

  modport slave (
    input  busRequest, busInputs,
    output busSelect, grantValid, grantId, busOutput
  );

  modport master (
    output busRequest, busInputs,
    input  busSelect, grantValid, grantId, busOutput
  );
endinterface

// File: rtl/internal_bus_arbiter.sv
// Round-robin internal bus arbiter with bounded hold time and one-hot bus select.
// Optional INTERNAL_BUS_ARB_LOCK_EN adds busLock, which suppresses forced rotation.
module internal_bus_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int WIDTH      = 8,
  parameter int MAX_HOLD   = 8
) (
  input logic clk,
  input logic nrst,
`ifdef INTERNAL_BUS_ARB_LOCK_EN
  input logic busLock,
`endif
  internal_bus_arbiter_if.slave bus
);
  localparam int IDW = $clog2(REQUESTERS);
  localparam int HCW = $clog2(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                state_q, state_d;
  logic [REQUESTERS-1:0] sel_q, sel_d;
  logic                  vld_q, vld_d;
  logic [IDW-1:0]        id_q, id_d;
  logic [IDW-1:0]        rr_q, rr_d;
  logic [HCW-1:0]        hold_q, hold_d;

  logic [REQUESTERS-1:0] req_m;
  logic                  win_found;
  logic [IDW-1:0]        win_id;
  logic                  lock_act;

`ifdef INTERNAL_BUS_ARB_LOCK_EN
  assign lock_act = busLock & vld_q;
`else
  assign lock_act = 1'b0;
`endif

  // The owner is masked out, so one scan serves both hand-off and forced rotation.
  assign req_m = bus.busRequest & ~((state_q == OWNED) ? sel_q : '0);

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int off = 1; off <= REQUESTERS; off++) begin
      if (!win_found && req_m[(int'(rr_q) + off) % REQUESTERS]) begin
        win_found = 1'b1;
        win_id    = IDW'((int'(rr_q) + off) % REQUESTERS);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    vld_d   = vld_q;
    id_d    = id_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          sel_d         = '0;
          sel_d[win_id] = 1'b1;
          id_d          = win_id;
          rr_d          = win_id;
          vld_d         = 1'b1;
          hold_d        = '0;
          state_d       = OWNED;
        end
      end
      OWNED: begin
        if (!bus.busRequest[id_q]) begin
          if (win_found) begin
            sel_d         = '0;
            sel_d[win_id] = 1'b1;
            id_d          = win_id;
            rr_d          = win_id;
            hold_d        = '0;
          end else begin
            sel_d   = '0;
            vld_d   = 1'b0;
            id_d    = '0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end else if (hold_q == HOLD_LAST) begin
          if (lock_act) begin
            hold_d = HOLD_LAST;
          end else if (win_found) begin
            sel_d         = '0;
            sel_d[win_id] = 1'b1;
            id_d          = win_id;
            rr_d          = win_id;
            hold_d        = '0;
          end else begin
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      rr_q    <= IDW'(REQUESTERS - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
    end
  end

  // AND-OR mux: select is one-hot or zero, so the idle output is naturally zero.
  logic [REQUESTERS-1:0][WIDTH-1:0] masked;
  logic [WIDTH-1:0]                 mux_out;

  for (genvar i = 0; i < REQUESTERS; i++) begin : g_mask
    assign masked[i] = bus.busInputs[WIDTH*i +: WIDTH] & {WIDTH{sel_q[i]}};
  end

  always_comb begin
    mux_out = '0;
    for (int i = 0; i < REQUESTERS; i++) mux_out = mux_out | masked[i];
  end

  assign bus.busSelect  = sel_q;
  assign bus.grantValid = vld_q;
  assign bus.grantId    = id_q;
  assign bus.busOutput  = mux_out;
endmodule

// File: tb/tb_internal_bus_arbiter.sv
// Directed self-checking bench for internal_bus_arbiter (REQUESTERS=4, WIDTH=8, MAX_HOLD=8).
module tb_internal_bus_arbiter;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   errors = 0;
  int   checks = 0;
`ifdef INTERNAL_BUS_ARB_LOCK_EN
  logic busLock = 1'b0;
`endif

  always #5 clk = ~clk;

  internal_bus_arbiter_if #(.REQUESTERS(4), .WIDTH(8)) bif ();

  internal_bus_arbiter #(.REQUESTERS(4), .WIDTH(8), .MAX_HOLD(8)) dut (
    .clk (clk),
    .nrst(nrst),
`ifdef INTERNAL_BUS_ARB_LOCK_EN
    .busLock(busLock),
`endif
    .bus (bif.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    bif.busRequest = '0;
    tick();
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    bif.busRequest = '0;
    bif.busInputs  = 32'h44_33_22_11;
    nrst = 1'b0;
    tick(); tick();
    checks++;
    if (bif.busSelect !== 4'b0000 || bif.grantValid !== 1'b0 || bif.grantId !== 2'd0 || bif.busOutput !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: sel=%b vld=%b id=%0d out=%h, want 0000/0/0/00",
               bif.busSelect, bif.grantValid, bif.grantId, bif.busOutput);
    end
    nrst = 1'b1;
    tick();
    checks++;
    if (bif.busSelect !== 4'b0000 || bif.grantValid !== 1'b0 || bif.grantId !== 2'd0 || bif.busOutput !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: sel=%b vld=%b id=%0d out=%h, want 0000/0/0/00",
               bif.busSelect, bif.grantValid, bif.grantId, bif.busOutput);
    end
  endtask

  task automatic test_single_grant();
    bif.busInputs  = 32'h44_A5_22_11;
    bif.busRequest = 4'b0100;
    tick();
    checks++;
    if (bif.busSelect !== 4'b0100 || bif.grantValid !== 1'b1 || bif.grantId !== 2'd2 || bif.busOutput !== 8'hA5) begin
      errors++;
      $display("FAIL single_grant: sel=%b vld=%b id=%0d out=%h, want 0100/1/2/a5",
               bif.busSelect, bif.grantValid, bif.grantId, bif.busOutput);
    end
    bif.busInputs = 32'h44_3C_22_11;
    #1;
    checks++;
    if (bif.busOutput !== 8'h3C) begin
      errors++;
      $display("FAIL data_follow: out=%h want 3c", bif.busOutput);
    end
    bif.busRequest = 4'b0000;
    tick();
    checks++;
    if (bif.busSelect !== 4'b0000 || bif.grantValid !== 1'b0 || bif.grantId !== 2'd0 || bif.busOutput !== 8'h00) begin
      errors++;
      $display("FAIL release_idle: sel=%b vld=%b id=%0d out=%h, want 0000/0/0/00",
               bif.busSelect, bif.grantValid, bif.grantId, bif.busOutput);
    end
  endtask

  task automatic test_glitch();
    bif.busRequest = 4'b0001;
    #3;
    bif.busRequest = 4'b0000;
    tick();
    checks++;
    if (bif.grantValid !== 1'b0 || bif.busSelect !== 4'b0000) begin
      errors++;
      $display("FAIL glitch_ignored: vld=%b sel=%b, want 0/0000", bif.grantValid, bif.busSelect);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_sel;
    do_reset();
    bif.busInputs  = 32'h44_33_22_11;
    bif.busRequest = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_sel = 4'b0001 << exp_order[k];
      checks++;
      if (bif.grantValid !== 1'b1 || bif.grantId !== 2'(exp_order[k]) || bif.busSelect !== exp_sel) begin
        errors++;
        $display("FAIL rr_step%0d: vld=%b id=%0d sel=%b, want 1/%0d/%b",
                 k, bif.grantValid, bif.grantId, bif.busSelect, exp_order[k], exp_sel);
      end
      bif.busRequest = 4'b1111 & ~exp_sel;
    end
    bif.busRequest = 4'b0000;
    tick();
  endtask

  task automatic test_hold_limit();
    do_reset();
    bif.busRequest = 4'b0010;
    tick();
    checks++;
    if (bif.grantId !== 2'd1 || bif.grantValid !== 1'b1) begin
      errors++;
      $display("FAIL hold_first: id=%0d vld=%b, want 1/1", bif.grantId, bif.grantValid);
    end
    bif.busRequest = 4'b1010;
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      if (bif.busSelect !== 4'b0010) begin
        errors++;
        $display("FAIL hold_cycle%0d: sel=%b want 0010", k + 2, bif.busSelect);
      end
    end
    tick();
    checks++;
    if (bif.busSelect !== 4'b1000 || bif.grantId !== 2'd3) begin
      errors++;
      $display("FAIL forced_rotation: sel=%b id=%0d, want 1000/3", bif.busSelect, bif.grantId);
    end
    bif.busRequest = 4'b0010;
    tick();
    checks++;
    if (bif.busSelect !== 4'b0010) begin
      errors++;
      $display("FAIL handoff_back: sel=%b want 0010", bif.busSelect);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (bif.busSelect !== 4'b0010 || bif.grantValid !== 1'b1) begin
        errors++;
        $display("FAIL keep_alone%0d: sel=%b vld=%b, want 0010/1", k, bif.busSelect, bif.grantValid);
      end
    end
    bif.busRequest = 4'b0000;
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    bif.busRequest = 4'b0100;
    tick();
    bif.busRequest = 4'b1111;
    tick();
    checks++;
    if (bif.grantId !== 2'd2) begin
      errors++;
      $display("FAIL pre_reset_owner: id=%0d want 2", bif.grantId);
    end
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if (bif.busSelect !== 4'b0000 || bif.grantValid !== 1'b0 || bif.grantId !== 2'd0 || bif.busOutput !== 8'h00) begin
      errors++;
      $display("FAIL async_clear: sel=%b vld=%b id=%0d out=%h, want 0000/0/0/00",
               bif.busSelect, bif.grantValid, bif.grantId, bif.busOutput);
    end
    tick();
    nrst = 1'b1;
    tick();
    checks++;
    if (bif.busSelect !== 4'b0001 || bif.grantId !== 2'd0 || bif.busOutput !== 8'h11) begin
      errors++;
      $display("FAIL post_reset_grant: sel=%b id=%0d out=%h, want 0001/0/11",
               bif.busSelect, bif.grantId, bif.busOutput);
    end
    bif.busRequest = 4'b0000;
    tick();
  endtask

`ifdef INTERNAL_BUS_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    busLock = 1'b1;
    bif.busRequest = 4'b0011;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (bif.busSelect !== 4'b0001) begin
        errors++;
        $display("FAIL lock_hold%0d: sel=%b want 0001", k, bif.busSelect);
      end
    end
    busLock = 1'b0;
    tick();
    checks++;
    if (bif.busSelect !== 4'b0010 || bif.grantId !== 2'd1) begin
      errors++;
      $display("FAIL lock_drop: sel=%b id=%0d, want 0010/1", bif.busSelect, bif.grantId);
    end
    bif.busRequest = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    bif.busRequest = '0;
    bif.busInputs  = '0;
    test_reset();
    test_single_grant();
    test_glitch();
    test_round_robin();
    test_hold_limit();
    test_mid_reset();
`ifdef INTERNAL_BUS_ARB_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
